microcode_sequencer: RTL



---
 rtl/mosby_decoder_pkg.sv | 66 ++++++
 rtl/microcode_rom.sv | 62 ++++++
 rtl/microcode_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mosby_decoder_pkg.sv
// Shared constants, opcode encodings and the control-word type for the
// 6502 micro-step decoder.
package mosby_decoder_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_SBC  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_EOR  = 4'd4;
  localparam logic [3:0] ALU_ORA  = 4'd5;
  localparam logic [3:0] ALU_ASL  = 4'd6;
  localparam logic [3:0] ALU_LSR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;
  localparam logic [3:0] ALU_INC  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  localparam logic [1:0] OPM_X   = 2'd0;
  localparam logic [1:0] OPM_Y   = 2'd1;
  localparam logic [1:0] OPM_SP  = 2'd2;
  localparam logic [1:0] OPM_IMM = 2'd3;

  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_ADC = 8'h69;
  localparam logic [7:0] OP_SBC = 8'hE9;
  localparam logic [7:0] OP_AND = 8'h29;
  localparam logic [7:0] OP_EOR = 8'h49;
  localparam logic [7:0] OP_ORA = 8'h09;
  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_TAX = 8'hAA;
  localparam logic [7:0] OP_TAY = 8'hA8;
  localparam logic [7:0] OP_JMP = 8'h4C;

  typedef struct packed {
    logic       w_rd;
    logic       pc_data;
    logic       increment;
    logic       lower_byte;
    logic       x_con;
    logic       y_con;
    logic       accumulator_con;
    logic       status_con;
    logic       stack_pointer_con;
    logic       branch_uncon;
    logic       branch_con;
    logic [3:0] alu_op;
    logic [2:0] branch_op;
    logic [1:0] operand_mux_con;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    w_rd: 1'b0, pc_data: 1'b1, increment: 1'b1, lower_byte: 1'b0,
    x_con: 1'b0, y_con: 1'b0, accumulator_con: 1'b0, status_con: 1'b0,
    stack_pointer_con: 1'b0, branch_uncon: 1'b0, branch_con: 1'b0,
    alu_op: ALU_PASS, branch_op: 3'd0, operand_mux_con: OPM_X
  };

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      OP_NOP, OP_ADC, OP_SBC, OP_AND, OP_EOR, OP_ORA, OP_LDA,
      OP_TAX, OP_TAY, OP_JMP: is_legal = 1'b1;
      default:                is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational opcode/step table: control word, last-step and legal flags.
module microcode_rom
  import mosby_decoder_pkg::*;
#(
  parameter int IR_W   = 8,
  parameter int STEP_W = 3
) (
  input  logic [IR_W-1:0]   i_opcode,
  input  logic [STEP_W-1:0] i_step,
  output ctrl_t             o_ctrl,
  output logic              o_last,
  output logic              o_legal
);

  always_comb begin
    o_ctrl  = CTRL_NOP;
    o_last  = 1'b1;
    o_legal = 1'b1;
    case (i_opcode)
      OP_NOP: ;
      OP_ADC, OP_SBC, OP_AND, OP_EOR, OP_ORA, OP_LDA: begin
        if (i_step == '0) begin
          o_last                 = 1'b0;
          o_ctrl.accumulator_con = 1'b1;
          o_ctrl.status_con      = 1'b1;
          o_ctrl.operand_mux_con = OPM_IMM;
          case (i_opcode)
            OP_ADC:  o_ctrl.alu_op = ALU_ADC;
            OP_SBC:  o_ctrl.alu_op = ALU_SBC;
            OP_AND:  o_ctrl.alu_op = ALU_AND;
            OP_EOR:  o_ctrl.alu_op = ALU_EOR;
            OP_ORA:  o_ctrl.alu_op = ALU_ORA;
            default: o_ctrl.alu_op = ALU_PASS;
          endcase
        end
      end
      OP_TAX, OP_TAY: begin
        if (i_step == '0) begin
          o_last            = 1'b0;
          o_ctrl.x_con      = (i_opcode == OP_TAX);
          o_ctrl.y_con      = (i_opcode == OP_TAY);
          o_ctrl.status_con = 1'b1;
          o_ctrl.increment  = 1'b0;
        end
      end
      OP_JMP: begin
        // step 0 fetches the low byte, step 1 the high byte, step 2 jumps
        if (i_step == '0) begin
          o_last = 1'b0;
        end else if (i_step == STEP_W'(1)) begin
          o_last            = 1'b0;
          o_ctrl.lower_byte = 1'b1;
        end else if (i_step == STEP_W'(2)) begin
          o_ctrl.branch_uncon = 1'b1;
          o_ctrl.increment    = 1'b0;
        end
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Instruction register, micro-step counter, fetch handshake and stall/normal
// gating around the microcode ROM.
module microcode_sequencer
  import mosby_decoder_pkg::*;
#(
  parameter int              IR_W       = 8,
  parameter int              STEP_W     = 3,
  parameter logic [IR_W-1:0] NOP_OPCODE = 8'hEA
) (
  input  logic              clk_2,
  input  logic              rst,
  input  logic              i_normal,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_instr_valid,
  input  logic [IR_W-1:0]   i_instruction,
  output logic              o_instr_ready,
  output logic              o_busy,
  output logic [STEP_W-1:0] o_step,
  output logic              o_illegal,
  output logic              o_w_rd,
  output logic              o_pc_data,
  output logic              o_increment,
  output logic              o_lower_byte,
  output logic              o_x_con,
  output logic              o_y_con,
  output logic              o_accumulator_con,
  output logic              o_status_con,
  output logic              o_stack_pointer_con,
  output logic              o_branch_uncon,
  output logic              o_branch_con,
  output logic [3:0]        o_alu_op,
  output logic [2:0]        o_branch_op,
  output logic [1:0]        o_operand_mux_con
);

  logic [IR_W-1:0]   r_ir;
  logic [STEP_W-1:0] r_step;
  logic              r_illegal;
  ctrl_t             w_rom_ctrl;
  ctrl_t             w_ctrl;
  logic              w_last;
  logic              w_legal;

  microcode_rom #(.IR_W(IR_W), .STEP_W(STEP_W)) u_rom (
    .i_opcode (r_ir),
    .i_step   (r_step),
    .o_ctrl   (w_rom_ctrl),
    .o_last   (w_last),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      r_ir      <= NOP_OPCODE;
      r_step    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (i_flush || !i_normal) begin
        r_ir   <= NOP_OPCODE;
        r_step <= '0;
      end else if (i_stall) begin
        r_ir   <= r_ir;
        r_step <= r_step;
      end else if (w_last) begin
        r_step <= '0;
        if (i_instr_valid) begin
          r_ir      <= i_instruction;
          r_illegal <= !is_legal(i_instruction);
        end else begin
          r_ir <= NOP_OPCODE;
        end
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  // stall freezes side effects only; ALU/mux selects keep their decode
  always_comb begin
    w_ctrl = w_rom_ctrl;
    if (!i_normal) begin
      w_ctrl = CTRL_NOP;
    end else if (i_stall) begin
      w_ctrl.x_con             = 1'b0;
      w_ctrl.y_con             = 1'b0;
      w_ctrl.accumulator_con   = 1'b0;
      w_ctrl.status_con        = 1'b0;
      w_ctrl.stack_pointer_con = 1'b0;
      w_ctrl.lower_byte        = 1'b0;
      w_ctrl.branch_uncon      = 1'b0;
      w_ctrl.branch_con        = 1'b0;
      w_ctrl.increment         = 1'b0;
    end
  end

  assign o_instr_ready       = w_last;
  assign o_busy              = (r_step != '0);
  assign o_step              = r_step;
  assign o_illegal           = r_illegal;
  assign o_w_rd              = w_ctrl.w_rd;
  assign o_pc_data           = w_ctrl.pc_data;
  assign o_increment         = w_ctrl.increment;
  assign o_lower_byte        = w_ctrl.lower_byte;
  assign o_x_con             = w_ctrl.x_con;
  assign o_y_con             = w_ctrl.y_con;
  assign o_accumulator_con   = w_ctrl.accumulator_con;
  assign o_status_con        = w_ctrl.status_con;
  assign o_stack_pointer_con = w_ctrl.stack_pointer_con;
  assign o_branch_uncon      = w_ctrl.branch_uncon;
  assign o_branch_con        = w_ctrl.branch_con;
  assign o_alu_op            = w_ctrl.alu_op;
  assign o_branch_op         = w_ctrl.branch_op;
  assign o_operand_mux_con   = w_ctrl.operand_mux_con;

  logic w_unused;
  assign w_unused = w_legal;

endmodule
